// File: rtl/mem_access_unit_if.sv
// Word-wide data memory bus with a req/ack handshake and variable latency.
// The load/store unit is the master; the memory is the slave.
interface mem_access_unit_if;
  logic        mreq;
  logic        mwe;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [3:0]  mbe;
  logic [31:0] mrdata;
  logic        mack;

  modport master (
    output mreq, mwe, maddr, mwdata, mbe,
    input  mrdata, mack
  );

  modport slave (
    input  mreq, mwe, maddr, mwdata, mbe,
    output mrdata, mack
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: stalls the core while one memory access is outstanding, aligns
// store lanes, extends loads and reports misaligned accesses and bus timeouts.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misaligned,
  output logic              bus_err,
  mem_access_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       acc_lane;
  logic [2:0]       acc_f3;
  logic             act;
  logic             bad;
  logic             timeout;
  logic [31:0]      st_data;
  logic [3:0]       st_be;

  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  // Request decode; a store wins when both strobes are high.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    act = mem_read | mem_write;
    bad = 1'b0;
    if (mem_write) bad = (funct3 > 3'b010);
    else           bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    if (funct3[1:0] == 2'b01 && addr[0])          bad = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) bad = 1'b1;
  end

  always_comb begin
    st_data = wdata;
    st_be   = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_data = {4{wdata[7:0]}};
        st_be   = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_data = {2{wdata[15:0]}};
        st_be   = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    misaligned = 1'b0;
    case (state)
      IDLE: begin
        if (act) begin
          if (bad) begin
            misaligned = 1'b1;
          end else begin
            stall      = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus.mack || timeout) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // NOTE: these outputs are combinational, so they are forced low while reset is held.
    if (!reset) begin
      stall      = 1'b0;
      misaligned = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mreq   <= 1'b0;
      bus.mwe    <= 1'b0;
      bus.maddr  <= '0;
      bus.mwdata <= '0;
      bus.mbe    <= '0;
      rdata      <= '0;
      bus_err    <= 1'b0;
      cnt        <= '0;
      acc_lane   <= '0;
      acc_f3     <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus_err <= 1'b0;
          if (act && !bad) begin
            bus.mreq   <= 1'b1;
            bus.mwe    <= mem_write;
            bus.maddr  <= {addr[31:2], 2'b00};
            bus.mwdata <= mem_write ? st_data : 32'd0;
            bus.mbe    <= mem_write ? st_be : 4'b1111;
            cnt        <= '0;
            acc_lane   <= addr[1:0];
            acc_f3     <= funct3;
          end
        end
        REQ: begin
          if (bus.mack) begin
            bus.mreq <= 1'b0;
            rdata    <= bus.mwe ? 32'd0 : load_ext(bus.mrdata, acc_lane, acc_f3);
          end else if (timeout) begin
            bus.mreq <= 1'b0;
            rdata    <= '0;
            bus_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: bus_err <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit against a behavioural model of
// access legality, lane placement, load extension and handshake timing.
module tb_mem_access_unit;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        misaligned;
  logic        bus_err;

  int n_cmp = 0;
  int n_fail = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: value the core should see for a load of 'word' at byte address 'a'.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
    logic [31:0] v;
    int unsigned off;
    off = a % 4;
    case (f3 % 4)
      0: begin
        v = (word >> (8 * off)) & 32'hFF;
        if (f3 < 4 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      1: begin
        v = (word >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 < 4 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  // One core access started while the DUT is idle; lat = REQ cycle carrying mack (0 = never).
  task automatic run_access(input string nm, input bit ld, input bit st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input int lat,
                            input logic [31:0] word);
    bit          bad, tmo;
    int unsigned sz, n_req;
    logic [31:0] exp_rd, exp_be, exp_wd;

    sz = 1 << (f3 % 4);
    if (st) bad = (f3 > 2);
    else    bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (a % sz != 0) bad = 1'b1;

    mem_read = ld; mem_write = st; funct3 = f3; addr = a; wdata = wd;
    #1;
    check({nm, ".misaligned"}, 32'(misaligned), 32'(bad));
    check({nm, ".stall0"}, 32'(stall), 32'(!bad));
    if (bad) begin
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      check({nm, ".no_mreq"}, 32'(bus.mreq), 32'd0);
      check({nm, ".pulse_end"}, 32'(misaligned), 32'd0);
      return;
    end

    tmo    = (lat == 0 || lat > int'(TIMEOUT));
    n_req  = tmo ? TIMEOUT : lat;
    exp_rd = (st || tmo) ? 32'd0 : ref_load(f3, a, word);
    if (!st)              begin exp_be = 32'hF; exp_wd = 32'd0; end
    else if (f3 == 3'd0)  begin exp_be = 32'd1 << (a % 4); exp_wd = (wd & 32'hFF) * 32'h0101_0101; end
    else if (f3 == 3'd1)  begin exp_be = 32'd3 << (a % 4); exp_wd = (wd & 32'hFFFF) * 32'h0001_0001; end
    else                  begin exp_be = 32'hF; exp_wd = wd; end

    for (int k = 1; k <= int'(n_req); k++) begin
      @(negedge clk);
      bus.mack   = (k == lat);
      bus.mrdata = word;
      #1;
      check($sformatf("%s.mreq%0d", nm, k), 32'(bus.mreq), 32'd1);
      check($sformatf("%s.stall%0d", nm, k), 32'(stall), 32'd1);
      if (k == 1) begin
        check({nm, ".maddr"}, bus.maddr, a & 32'hFFFF_FFFC);
        check({nm, ".mbe"}, 32'(bus.mbe), exp_be);
        check({nm, ".mwe"}, 32'(bus.mwe), 32'(st));
        if (st) check({nm, ".mwdata"}, bus.mwdata, exp_wd);
      end
    end

    @(negedge clk);
    bus.mack = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check({nm, ".done_stall"}, 32'(stall), 32'd0);
    check({nm, ".done_mreq"}, 32'(bus.mreq), 32'd0);
    check({nm, ".bus_err"}, 32'(bus_err), 32'(tmo));
    check({nm, ".rdata"}, rdata, exp_rd);
    @(negedge clk);
    #1;
    check({nm, ".idle_err"}, 32'(bus_err), 32'd0);
    check({nm, ".idle_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    bus.mack = 1'b0;
    bus.mrdata = '0;

    // Reset with an active (and misaligned) request on the inputs.
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h66;
    #23;
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.misaligned", 32'(misaligned), 32'd0);
    check("rst.mreq", 32'(bus.mreq), 32'd0);
    check("rst.mwe", 32'(bus.mwe), 32'd0);
    check("rst.maddr", bus.maddr, 32'd0);
    check("rst.mwdata", bus.mwdata, 32'd0);
    check("rst.mbe", 32'(bus.mbe), 32'd0);
    check("rst.rdata", rdata, 32'd0);
    check("rst.bus_err", 32'(bus_err), 32'd0);
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_access("sw64", 0, 1, 3'b010, 32'h64, 32'd25, 3, 32'h0);
    run_access("lb103", 1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_1234);
    run_access("lbu103", 1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_1234);
    run_access("lhu102", 1, 0, 3'b101, 32'h102, 32'h0, 1, 32'h80FF_1234);
    run_access("lh102", 1, 0, 3'b001, 32'h102, 32'h0, 2, 32'h80FF_1234);
    run_access("sh22", 0, 1, 3'b001, 32'h22, 32'hABCD_1234, 1, 32'h0);
    run_access("sb_both", 1, 1, 3'b000, 32'h41, 32'h0000_00A5, 2, 32'h0);
    run_access("lw66", 1, 0, 3'b010, 32'h66, 32'h0, 1, 32'h0);
    run_access("lf3_011", 1, 0, 3'b011, 32'h40, 32'h0, 1, 32'h0);
    run_access("sf3_100", 0, 1, 3'b100, 32'h40, 32'h0, 1, 32'h0);
    run_access("lw_tmo", 1, 0, 3'b010, 32'h80, 32'h0, 0, 32'hDEAD_BEEF);
    run_access("lw_last", 1, 0, 3'b010, 32'h84, 32'h0, int'(TIMEOUT), 32'h1357_9BDF);

    // A stray acknowledge while idle must not start or finish anything.
    bus.mack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("stray.mreq", 32'(bus.mreq), 32'd0);
    check("stray.stall", 32'(stall), 32'd0);
    check("stray.bus_err", 32'(bus_err), 32'd0);
    bus.mack = 1'b0;
    @(negedge clk);

    // Reset asserted on the second REQ cycle of a load.
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h200;
    repeat (2) @(negedge clk);
    #1;
    check("mid.mreq_before", 32'(bus.mreq), 32'd1);
    reset = 1'b0;
    #1;
    check("mid.mreq", 32'(bus.mreq), 32'd0);
    check("mid.stall", 32'(stall), 32'd0);
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("mid.after_mreq", 32'(bus.mreq), 32'd0);
    check("mid.after_stall", 32'(stall), 32'd0);

    for (int i = 0; i < 40; i++) begin
      bit          ld, st;
      logic [31:0] a;
      int          lat;
      int unsigned kind;
      kind = $urandom_range(0, 3);
      ld = (kind != 1);
      st = (kind == 1 || kind == 2);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
      run_access($sformatf("rnd%0d", i), ld, st, 3'($urandom_range(0, 7)), a, $urandom,
                 lat, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
